// File: rtl/extender_pkg.sv
// Shared types and helpers for the RV32I immediate extender.
package extender_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_SB = 3'd2,
        IMM_U  = 3'd3
    } imm_sel_e;

    // Codes 4-7 are reserved.
    function automatic logic is_legal_sel(input logic [2:0] sel);
        return !sel[2];
    endfunction

endpackage

// File: rtl/extender_imm_decode.sv
// Combinational assembly and sign-extension of I/S/SB/U immediates.
module imm_decode
    import extender_pkg::*;
(
    input  logic [2:0]      selector,
    input  logic [XLEN-1:7] in,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (selector)
            IMM_I:  imm = {{20{in[31]}}, in[31:20]};
            IMM_S:  imm = {{20{in[31]}}, in[31:25], in[11:7]};
            IMM_SB: imm = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
            IMM_U:  imm = {in[31:12], 12'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/extender.sv
// Registered immediate extender aligned with the register-file read stage.
module extender
    import extender_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       selector,
    input  logic [WIDTH-1:7] in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             illegal
);

    logic [XLEN-1:0] imm;

    imm_decode u_decode (
        .selector (selector),
        .in       (in),
        .imm      (imm)
    );

    // out/illegal hold across idle cycles; only out_valid tracks in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out     <= imm;
                illegal <= !is_legal_sel(selector);
            end
        end
    end

endmodule

// File: tb/tb_extender.sv
// Directed self-checking bench for the immediate extender.
module tb_extender;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  selector;
    logic [31:7] in;
    logic        in_valid;
    logic [31:0] out;
    logic        out_valid;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    extender #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .selector  (selector),
        .in        (in),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Inputs change #1 after an edge; outputs are sampled #1 after the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; selector = 3'd0; in = '0;
        step();
        reset = 1'b0;
        n_cmp++; if (out !== 32'h0 || out_valid !== 1'b0 || illegal !== 1'b0) begin
            n_bad++; $display("FAIL reset_init: out=%h v=%b ill=%b want 0/0/0", out, out_valid, illegal);
        end
        // Load a nonzero illegal result, then reset during a valid input.
        in_valid = 1'b1; selector = 3'd7; in = '1;
        step();
        reset = 1'b1; selector = 3'd0;
        step();
        reset = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out !== 32'h0 || out_valid !== 1'b0 || illegal !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid: out=%h v=%b ill=%b want 0/0/0", out, out_valid, illegal);
        end
    endtask

    task automatic test_i_type();
        in_valid = 1'b1; selector = 3'd0; in = 25'b1000000000000000000000000;
        step();
        n_cmp++; if (out !== 32'hFFFFF800 || out_valid !== 1'b1 || illegal !== 1'b0) begin
            n_bad++; $display("FAIL i_neg: out=%h v=%b ill=%b want FFFFF800/1/0", out, out_valid, illegal);
        end
        in = '0;
        step();
        n_cmp++; if (out !== 32'h00000000 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL i_zero: out=%h v=%b want 00000000/1", out, out_valid);
        end
        in = 25'b0111111111110000000000000;
        step();
        n_cmp++; if (out !== 32'h000007FF) begin
            n_bad++; $display("FAIL i_pos: out=%h want 000007FF", out);
        end
    endtask

    task automatic test_s_type();
        in_valid = 1'b1; selector = 3'd1; in = 25'b1000000000000000000011111;
        step();
        n_cmp++; if (out !== 32'hFFFFF81F) begin
            n_bad++; $display("FAIL s_neg: out=%h want FFFFF81F", out);
        end
        in = 25'b0000000000000000000011111;
        step();
        n_cmp++; if (out !== 32'h0000001F) begin
            n_bad++; $display("FAIL s_pos: out=%h want 0000001F", out);
        end
    endtask

    task automatic test_sb_type();
        in_valid = 1'b1; selector = 3'd2; in = 25'b1000000000000000000000000;
        step();
        n_cmp++; if (out !== 32'hFFFFF000) begin
            n_bad++; $display("FAIL sb_sign: out=%h want FFFFF000", out);
        end
        in = 25'b1100000000000000000011111;
        step();
        n_cmp++; if (out !== 32'hFFFFFC1E) begin
            n_bad++; $display("FAIL sb_mix: out=%h want FFFFFC1E", out);
        end
    endtask

    task automatic test_u_type();
        in_valid = 1'b1; selector = 3'd3; in = 25'b1000000000000000000000000;
        step();
        n_cmp++; if (out !== 32'h80000000) begin
            n_bad++; $display("FAIL u_sign: out=%h want 80000000", out);
        end
        in = 25'b1100000000011100001100000;
        step();
        n_cmp++; if (out !== 32'hC01C3000) begin
            n_bad++; $display("FAIL u_mix: out=%h want C01C3000", out);
        end
    endtask

    task automatic test_reserved_and_gating();
        in_valid = 1'b1; selector = 3'd5; in = 25'h1ABCDEF;
        step();
        n_cmp++; if (out !== 32'h0 || illegal !== 1'b1 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL reserved: out=%h v=%b ill=%b want 0/1/1", out, out_valid, illegal);
        end
        // Idle cycle: different inputs must not be captured.
        in_valid = 1'b0; selector = 3'd0; in = 25'b1000000000000000000000000;
        step();
        n_cmp++; if (out_valid !== 1'b0 || out !== 32'h0 || illegal !== 1'b1) begin
            n_bad++; $display("FAIL idle_hold: out=%h v=%b ill=%b want 0/0/1", out, out_valid, illegal);
        end
        // Hold a nonzero value across an idle cycle as well.
        in_valid = 1'b1; selector = 3'd3; in = 25'b1000000000000000000000000;
        step();
        in_valid = 1'b0; selector = 3'd1; in = '0;
        step();
        n_cmp++; if (out_valid !== 1'b0 || out !== 32'h80000000 || illegal !== 1'b0) begin
            n_bad++; $display("FAIL idle_hold2: out=%h v=%b ill=%b want 80000000/0/0", out, out_valid, illegal);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; selector = 3'd6; in = '0;
        step();
        selector = 3'd0; in = 25'b1000000000000000000000000;
        step();
        n_cmp++; if (out !== 32'hFFFFF800 || out_valid !== 1'b1 || illegal !== 1'b0) begin
            n_bad++; $display("FAIL b2b_i: out=%h v=%b ill=%b want FFFFF800/1/0", out, out_valid, illegal);
        end
        selector = 3'd3; in = 25'b1100000000011100001100000;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out !== 32'hC01C3000 || out_valid !== 1'b1 || illegal !== 1'b0) begin
            n_bad++; $display("FAIL b2b_u: out=%h v=%b ill=%b want C01C3000/1/0", out, out_valid, illegal);
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_end: v=%b want 0", out_valid);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; selector = '0; in = '0;
        #1;
        test_reset();
        test_i_type();
        test_s_type();
        test_sb_type();
        test_u_type();
        test_reserved_and_gating();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
